// File: rtl/pipe_pkg.sv
// pipe_pkg: per-stage control layouts and their bubble constants
package pipe_pkg;
  // EX/ME control: 12 functional bits padded to the 14-bit pipeline field
  typedef struct packed {
    logic [1:0] rsvd;
    logic       pcsrc;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       zero;
    logic       regwrite;
    logic [1:0] readdm_mux;
    logic [3:0] typ;
  } exme_ctrl_t;
  localparam int EXME_CTRL_W = $bits(exme_ctrl_t);
  localparam exme_ctrl_t EXME_CTRL_BUBBLE = '0;
endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot: one valid+ctrl+data entry with load, clear-to-bubble and async reset
module pipe_stage_slot #(
  parameter int CTRL_W = 14,
  parameter int DATA_W = 32,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  // clear leaves data untouched so the payload keeps its last value
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      valid <= 1'b0;
      ctrl  <= CTRL_BUBBLE;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= CTRL_BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry, flush and stall counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = EXME_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CTRL_W-1:0] InCtrl,
  input  logic [DATA_W-1:0] InData,
  input  logic              Flush,
  input  logic              ClrStats,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [DATA_W-1:0] OutData,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  StallCount
);
  logic              acc, drn, main_load, main_clear, skid_valid;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [DATA_W-1:0] main_data_in;
  assign acc = InValid && InReady;
  assign drn = OutValid && OutReady;
  assign main_clear = Flush || (drn && !main_load);
  assign Occupancy = {1'b0, OutValid} + {1'b0, skid_valid};
  pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_main (
    .Clk(Clk), .Rst_n(Rst_n), .load(main_load), .clear(main_clear),
    .in_ctrl(main_ctrl_in), .in_data(main_data_in),
    .valid(OutValid), .ctrl(OutCtrl), .data(OutData)
  );
  if (SKID != 0) begin : g_skid
    logic              skid_load, skid_clear;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    // while skid holds an entry InReady is low, so no accept competes with the skid->main move
    assign InReady = !skid_valid;
    assign main_load = !Flush && (skid_valid ? drn : acc && (!OutValid || drn));
    assign main_ctrl_in = skid_valid ? skid_ctrl : InCtrl;
    assign main_data_in = skid_valid ? skid_data : InData;
    assign skid_load = !Flush && acc && OutValid && !drn;
    assign skid_clear = Flush || (drn && skid_valid);
    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_skid (
      .Clk(Clk), .Rst_n(Rst_n), .load(skid_load), .clear(skid_clear),
      .in_ctrl(InCtrl), .in_data(InData),
      .valid(skid_valid), .ctrl(skid_ctrl), .data(skid_data)
    );
  end else begin : g_noskid
    assign InReady = !OutValid || OutReady;
    assign main_load = !Flush && acc;
    assign main_ctrl_in = InCtrl;
    assign main_data_in = InData;
    assign skid_valid = 1'b0;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) StallCount <= '0;
    else if (ClrStats) StallCount <= '0;
    else if (OutValid && !OutReady && StallCount != '1) StallCount <= StallCount + 1'b1;
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the processor datapath (IF/ID, ID/EX, EX/ME, ME/WB instances). It carries a control field and a data payload from one stage to the next with a valid/ready handshake, stall back-pressure, flush-to-bubble, and an optional skid entry that keeps the upstream ready path registered. All state updates on the rising clock edge. A saturating stall counter is included for bring-up debug.

## Interface
- DATA_W, 32: payload width (e.g. Result, RD2 and WriteReg packed by the instantiating stage).
- CTRL_W, 14: control field width.
- CTRL_BUBBLE, '0: control value driven whenever no valid entry is presented; all side-effect bits must be 0.
- SKID, 1: 1 gives a 2-entry register with registered InReady; 0 gives 1 entry with combinational InReady.
- CNT_W, 16: stall counter width.

- Clk  in  1  clock; rising edge only.
- Rst_n  in  1  asynchronous, active-low reset.
- InValid  in  1  upstream entry valid.
- InReady  out  1  block can accept this cycle.
- InCtrl  in  CTRL_W  upstream control field.
- InData  in  DATA_W  upstream payload.
- Flush  in  1  synchronous squash of all held entries.
- ClrStats  in  1  synchronous clear of StallCount.
- OutValid  out  1  downstream entry valid.
- OutReady  in  1  downstream accepts.
- OutCtrl  out  CTRL_W  held control; CTRL_BUBBLE when !OutValid.
- OutData  out  DATA_W  held payload.
- Occupancy  out  2  entries held, 0..2.
- StallCount  out  CNT_W  cycles with OutValid && !OutReady, saturating.

## Operation
- Accept = InValid && InReady; Drain = OutValid && OutReady. Entries leave in arrival order.
- Main entry drives the Out* ports. The skid entry exists only when SKID=1.
- SKID=1: InReady = !skid_valid (registered).
  - Main empty: accepted entry loads main.
  - Main full with Drain: accepted entry replaces main.
  - Main full without Drain: accepted entry loads skid.
  - Drain with skid full: skid moves to main and skid clears.
- SKID=0: InReady = !OutValid || OutReady. Accepted entry loads main.
- Flush has top priority. Next cycle both entries are invalid, OutCtrl = CTRL_BUBBLE, and an Accept in the Flush cycle is discarded. OutData keeps its last value.
- When main becomes invalid (drain without refill, or Flush), OutCtrl loads CTRL_BUBBLE on the same edge.
- StallCount increments by 1 per stall cycle and holds at 2^CNT_W-1. ClrStats sets it to 0 and wins over a same-cycle increment.

## Timing
- Reset values:
  - OutValid 0, OutCtrl CTRL_BUBBLE, OutData 0, Occupancy 0, StallCount 0.
  - skid_valid 0, so InReady = 1 once Rst_n is high.
  - Handshakes are ignored while Rst_n is low.
- Latency: an entry accepted at edge N appears on Out* after edge N, in the same cycle OutValid rises. Throughput is 1 entry per cycle when OutReady stays high.
- Back-pressure (SKID=1): the first stalled accept fills skid, and InReady falls after the next edge. No entry is lost or duplicated.
- After OutReady returns, InReady rises one cycle after the skid drains.
- Accept and Drain in the same cycle with skid empty: Occupancy stays at 1.
- Flush during back-pressure clears both entries. InReady is 1 the next cycle.
- Reset asserted mid-transfer clears all state immediately, asynchronously.

## Structure
- Shared package pipe_pkg holds:
  - per-stage control layouts as packed structs (EX/ME: PCSrc, MemtoReg, MemRead, MemWrite, Zero, RegWrite, ReadDMMux[1:0], Type[3:0]; 14 bits);
  - the matching CTRL_BUBBLE constants.
- Sub-module pipe_stage_slot: one valid+ctrl+data register with load, clear-to-bubble and async reset. It is instantiated once for main and once for skid under SKID=1.

## Test plan
- Reset, then InValid=1, InCtrl=14'h2A5, InData=32'hDEADBEEF, OutReady=1 -> one edge later OutValid=1, OutCtrl=14'h2A5, OutData=32'hDEADBEEF, Occupancy=1.
- Stream 8 entries (data 1..8) with OutReady=1 throughout -> outputs 1..8 on consecutive cycles, InReady never low.
- SKID=1, OutReady=0, push 1,2,3 -> 1 in main, 2 in skid, InReady=0, Occupancy=2, and 3 held upstream. Then OutReady=1 -> outputs 1,2,3 in order with no gaps.
- Occupancy=2, Flush=1 together with InValid=1 data 9 -> next cycle OutValid=0, OutCtrl=CTRL_BUBBLE, InReady=1, Occupancy=0, and 9 never appears.
- CNT_W=4, OutValid=1, OutReady=0 for 20 cycles -> StallCount=15 held. ClrStats=1 in a stall cycle -> StallCount=0.
- SKID=0, OutReady=0 with main full -> InReady=0 the same cycle. Rst_n dropped mid-stream -> Out* take reset values without a clock edge.
